gpu_vga_timing: RTL and testbench
=================================

# gpu_vga_timing

VGA raster timing generator for the Zucker GPU. Free-running horizontal and vertical counters produce the `x`/`y` scan coordinates that drive the text renderer. The block samples the renderer's 1-bit `pixel` return and emits `hsync`, `vsync`, `blank` and a gated `pixel_out`, all delayed to line up with the renderer's read latency. It sits directly upstream (coordinates) and downstream (pixel) of the text stage, at the DAC/pin boundary.

## Interface
- `H_VISIBLE`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, hsync width (clocks)
- `H_BACK`, 48, horizontal back porch (clocks)
- `V_VISIBLE`, 480, active lines
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `PIXEL_LAT`, 2, clocks from `x`/`y` change until the matching `pixel_in` is valid; range 1..4
- `clk`  in  1  pixel clock, 25.175 MHz nominal
- `resetn`  in  1  reset; asynchronous, active-low
- `x`  out  10  horizontal counter `hcnt`, 0..H_TOTAL-1
- `y`  out  10  vertical counter `vcnt`, 0..V_TOTAL-1
- `pixel_in`  in  1  renderer pixel for the coordinates issued PIXEL_LAT clocks earlier
- `hsync`  out  1  active-low horizontal sync
- `vsync`  out  1  active-low vertical sync
- `blank`  out  1  high outside the visible area
- `pixel_out`  out  1  `pixel_in` gated by not-blank, registered
- `vblank_irq`  out  1  one-clock pulse at vblank entry (see Configuration)
- `frame_count`  out  16  frame counter (see Configuration)

## Operation
- H_TOTAL = sum of the H params (800). V_TOTAL = sum of the V params (525).
- `hcnt` increments every clk. At H_TOTAL-1 it wraps to 0 and `vcnt` increments. `vcnt` wraps to 0 after V_TOTAL-1 at the same clk where `hcnt` wraps.
- `x`/`y` are the counter registers themselves, with no extra delay. Blank-region values (x 640..799, y 480..524) are driven unmodified.
- Raw terms are computed from the current counters:
  - active = hcnt<H_VISIBLE && vcnt<V_VISIBLE
  - hs_raw low for hcnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. [656,751]
  - vs_raw low for vcnt in [490,491], for whole lines
- The raw terms pass through a delay line of PIXEL_LAT+1 registers to form `hsync`, `vsync` and `blank` (= !active).
- `pixel_out` register <= `pixel_in` && active-delayed-by-PIXEL_LAT.
- Reset values, for all registers including every delay-line stage:
  - hcnt=0, vcnt=0
  - hsync=1, vsync=1, blank=1, pixel_out=0
  - vblank_irq=0, frame_count=0
- Asserting reset mid-line forces these values immediately (asynchronous). After release, counting restarts at (0,0) on the first rising clk.

## Timing
- Latency of `hsync`/`vsync`/`blank`/`pixel_out` relative to the counter state is PIXEL_LAT+1 clocks, identical for all four, so sync-to-pixel alignment is exact.
- The first visible `pixel_out` after reset appears at clk PIXEL_LAT+1 and reflects `pixel_in` sampled at clk PIXEL_LAT.
- Throughput: one pixel per clk, no stalls, no handshake.

## Configuration
- Macro `GPU_VGA_FRAME_IRQ_EN`.
- Defined:
  - `vblank_irq` pulses high for exactly one clk on the clk after the counters reach (hcnt=0, vcnt=V_VISIBLE). It is undelayed.
  - `frame_count` increments on that same edge and wraps 0xFFFF→0.
- Undefined: both outputs are tied to 0 and no counter logic is synthesised.

## Structure
- Shared package `gpu_pkg` holds the default 640x480@60 timing constants, H_TOTAL/V_TOTAL derivation, and the sync polarity constants.
- One sub-module, `gpu_delay_line`: parameterised width and depth, async active-low reset to a parameterised reset value. It carries {hs_raw, vs_raw, active}.

## Test plan
- Reset hold, then release:
  - during reset: x=0, y=0, hsync=1, vsync=1, blank=1, pixel_out=0
  - after release: x=1 at the first clk, blank falls at clk PIXEL_LAT+1.
- Run one line: hsync low for exactly 96 clks, starting PIXEL_LAT+1 clks after x=656 is driven. blank rises PIXEL_LAT+1 clks after x=640.
- Line wrap: x=799,y=5 → next clk x=0,y=6. Frame wrap: x=799,y=524 → x=0,y=0. vsync low for exactly 2×800 clks per frame.
- `pixel_in` held 1 for a full frame: `pixel_out` high for exactly 640×480 = 307200 clks, never while blank=1.
- Async reset asserted at x=300,y=100, off-edge: outputs return to reset values without a clk edge. The restart is clean.
- With `GPU_VGA_FRAME_IRQ_EN`: over 3 frames `vblank_irq` pulses 3 times, each 1 clk wide, 525×800 clks apart, and frame_count reads 3. Without the macro: both outputs stay 0.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared timing package for the Zucker GPU: default 640x480@60 raster constants,
// frame-size derivation, sync polarity and the raster-term bundle carried by the delay line.
package gpu_pkg;

   localparam int unsigned CNT_W = 10;

   function automatic int unsigned span_total(input int unsigned visible, input int unsigned front,
                                              input int unsigned sync, input int unsigned back);
      return visible + front + sync + back;
   endfunction

   localparam int unsigned DEF_H_VISIBLE = 640;
   localparam int unsigned DEF_H_FRONT   = 16;
   localparam int unsigned DEF_H_SYNC    = 96;
   localparam int unsigned DEF_H_BACK    = 48;
   localparam int unsigned DEF_V_VISIBLE = 480;
   localparam int unsigned DEF_V_FRONT   = 10;
   localparam int unsigned DEF_V_SYNC    = 2;
   localparam int unsigned DEF_V_BACK    = 33;

   localparam int unsigned DEF_H_TOTAL =
      span_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
   localparam int unsigned DEF_V_TOTAL =
      span_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

   // Both syncs are active-low for the 640x480@60 mode.
   localparam logic SYNC_ACTIVE = 1'b0;
   localparam logic SYNC_IDLE   = 1'b1;

   typedef struct packed {
      logic hs;
      logic vs;
      logic active;
   } raster_t;

   localparam raster_t RASTER_RESET = '{hs: SYNC_IDLE, vs: SYNC_IDLE, active: 1'b0};

endpackage

// File: rtl/gpu_delay_line.sv
// Fixed-depth shift register with asynchronous active-low reset of every stage
// to a parameterised value; used to align raster terms with renderer latency.
module gpu_delay_line #(
   parameter int unsigned          WIDTH     = 1,
   parameter int unsigned          DEPTH     = 1,
   parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [DEPTH];

   // NOTE: every stage is reset, not just the output, so no stale sync or blank
   // value can leak out during the first DEPTH clocks after reset release.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[DEPTH-1];

endmodule

// File: rtl/gpu_vga_timing.sv
// VGA raster timing generator: x/y counters, latency-aligned sync/blank/pixel outputs.
// Optional vblank interrupt and frame counter enabled by GPU_VGA_FRAME_IRQ_EN.
module gpu_vga_timing
   import gpu_pkg::*;
#(
   parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
   parameter int unsigned H_FRONT   = DEF_H_FRONT,
   parameter int unsigned H_SYNC    = DEF_H_SYNC,
   parameter int unsigned H_BACK    = DEF_H_BACK,
   parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
   parameter int unsigned V_FRONT   = DEF_V_FRONT,
   parameter int unsigned V_SYNC    = DEF_V_SYNC,
   parameter int unsigned V_BACK    = DEF_V_BACK,
   parameter int unsigned PIXEL_LAT = 2
) (
   input  logic             clk,
   input  logic             resetn,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   input  logic             pixel_in,
   output logic             hsync,
   output logic             vsync,
   output logic             blank,
   output logic             pixel_out,
   output logic             vblank_irq,
   output logic [15:0]      frame_count
);

   localparam int unsigned H_TOTAL = span_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
   localparam int unsigned V_TOTAL = span_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
   localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
   localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VISIBLE + H_FRONT);
   localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VISIBLE + V_FRONT);
   localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic [CNT_W-1:0] hcnt, vcnt;
   raster_t          raw, raw_dly;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (hcnt == H_LAST) begin
         hcnt <= '0;
         vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
         hcnt <= hcnt + 1'b1;
      end
   end

   assign x = hcnt;
   assign y = vcnt;

   always_comb begin
      raw        = RASTER_RESET;
      raw.hs     = (hcnt >= HS_FIRST && hcnt <= HS_LAST) ? SYNC_ACTIVE : SYNC_IDLE;
      raw.vs     = (vcnt >= VS_FIRST && vcnt <= VS_LAST) ? SYNC_ACTIVE : SYNC_IDLE;
      raw.active = (hcnt < H_VIS) && (vcnt < V_VIS);
   end

   // The first PIXEL_LAT stages live in the delay line; the output registers
   // below form the final stage, where the renderer's pixel is also gated.
   gpu_delay_line #(
      .WIDTH     ($bits(raster_t)),
      .DEPTH     (PIXEL_LAT),
      .RESET_VAL (RASTER_RESET)
   ) u_raster_dly (
      .clk    (clk),
      .resetn (resetn),
      .d      (raw),
      .q      (raw_dly)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hsync     <= SYNC_IDLE;
         vsync     <= SYNC_IDLE;
         blank     <= 1'b1;
         pixel_out <= 1'b0;
      end else begin
         hsync     <= raw_dly.hs;
         vsync     <= raw_dly.vs;
         blank     <= !raw_dly.active;
         pixel_out <= pixel_in && raw_dly.active;
      end
   end

`ifdef GPU_VGA_FRAME_IRQ_EN
   logic vblank_entry;
   assign vblank_entry = (hcnt == '0) && (vcnt == V_VIS);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vblank_irq  <= 1'b0;
         frame_count <= '0;
      end else begin
         vblank_irq <= vblank_entry;
         if (vblank_entry) frame_count <= frame_count + 16'd1;
      end
   end
`else
   assign vblank_irq  = 1'b0;
   assign frame_count = '0;
`endif

endmodule

// File: tb/tb_gpu_vga_timing.sv
// Randomised self-checking bench for gpu_vga_timing on a reduced raster so
// several whole frames fit in a short run; expectations come from frame arithmetic.
module tb_gpu_vga_timing;

   localparam int HV = 16, HF = 4, HS = 6, HB = 4;
   localparam int VV = 10, VF = 2, VS = 2, VB = 3;
   localparam int LAT = 2;
   localparam int HT  = HV + HF + HS + HB;
   localparam int VT  = VV + VF + VS + VB;
   localparam int FR  = HT * VT;
`ifdef GPU_VGA_FRAME_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetn;
   logic [9:0]  x, y;
   logic        pixel_in;
   logic        hsync, vsync, blank, pixel_out, vblank_irq;
   logic [15:0] frame_count;

   int errors = 0;
   int checks = 0;
   int t      = 0;

   always #5 clk = ~clk;

   gpu_vga_timing #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .PIXEL_LAT(LAT)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .x           (x),
      .y           (y),
      .pixel_in    (pixel_in),
      .hsync       (hsync),
      .vsync       (vsync),
      .blank       (blank),
      .pixel_out   (pixel_out),
      .vblank_irq  (vblank_irq),
      .frame_count (frame_count)
   );

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at t=%0d: got %0d expected %0d", tag, t, got, exp);
      end
   endtask

   // Raster position p (clocks since reset release) mapped onto the frame.
   function automatic int px(input int p); return p % HT;        endfunction
   function automatic int py(input int p); return (p / HT) % VT; endfunction
   function automatic bit in_active(input int p);
      return px(p) < HV && py(p) < VV;
   endfunction
   function automatic bit hs_level(input int p);
      return !(px(p) >= HV + HF && px(p) < HV + HF + HS);
   endfunction
   function automatic bit vs_level(input int p);
      return !(py(p) >= VV + VF && py(p) < VV + VF + VS);
   endfunction
   function automatic int fc_model(input int tt);
      if (!IRQ_EN || tt < VV * HT + 1) return 0;
      return ((tt - 1 - VV * HT) / FR + 1) % 65536;
   endfunction

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_x"}, x, 0);
      check({pfx, "_y"}, y, 0);
      check({pfx, "_hsync"}, hsync, 1);
      check({pfx, "_vsync"}, vsync, 1);
      check({pfx, "_blank"}, blank, 1);
      check({pfx, "_pixel_out"}, pixel_out, 0);
      check({pfx, "_irq"}, vblank_irq, 0);
      check({pfx, "_frame_count"}, frame_count, 0);
   endtask

   // Drive one pixel_in value into the next edge, then compare every output
   // with the position the model says is visible at the pins.
   task automatic step(input bit pin);
      int p;
      pixel_in = pin;
      @(posedge clk);
      t++;
      #1;
      check("x", x, px(t));
      check("y", y, py(t));
      if (t >= LAT + 1) begin
         p = t - LAT - 1;
         check("hsync", hsync, hs_level(p));
         check("vsync", vsync, vs_level(p));
         check("blank", blank, !in_active(p));
         check("pixel_out", pixel_out, pin && in_active(p));
      end else begin
         check("hsync_pre", hsync, 1);
         check("vsync_pre", vsync, 1);
         check("blank_pre", blank, 1);
         check("pixel_out_pre", pixel_out, 0);
      end
      check("irq", vblank_irq, IRQ_EN && ((t - 1) % FR == VV * HT));
      check("frame_count", frame_count, fc_model(t));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int hs_low = 0, vs_low = 0, pix_hi = 0, irq_n = 0, last_irq = 0;
      bit pin;

      resetn   = 1'b0;
      pixel_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset_hold");

      @(negedge clk);
      resetn = 1'b1;
      t      = 0;

      // Frame 1 random, frame 2 pixel_in held high, frame 3 random.
      for (int i = 0; i < 3 * FR; i++) begin
         pin = (t + 1 >= FR + 1 && t + 1 <= 2 * FR) ? 1'b1 : 1'($urandom_range(1, 0));
         step(pin);
         if (t >= LAT + 2 && t <= LAT + 1 + HT) hs_low += !hsync;
         if (t >= LAT + 2 && t <= LAT + 1 + FR) vs_low += !vsync;
         if (t >= FR + 1 && t <= 2 * FR) pix_hi += pixel_out;
         if (vblank_irq) begin
            irq_n++;
            if (last_irq > 0) check("irq_spacing", t - last_irq, FR);
            last_irq = t;
         end
      end
      check("hsync_low_per_line", hs_low, HS);
      check("vsync_low_per_frame", vs_low, VS * HT);
      check("pixels_per_frame", pix_hi, HV * VV);
      check("irq_pulses_3_frames", irq_n, IRQ_EN ? 3 : 0);
      check("frame_count_3_frames", frame_count, IRQ_EN ? 3 : 0);

      // Walk to mid-line, mid-frame and pull reset between clock edges.
      for (int i = 0; i < 2 * FR && (t % FR) != 4 * HT + 7; i++) step(1'($urandom_range(1, 0)));
      check("reached_mid_x", x, 7);
      check("reached_mid_y", y, 4);
      #2;
      resetn = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset_held");
      @(negedge clk);
      resetn = 1'b1;
      t      = 0;
      for (int i = 0; i < 2 * FR; i++) step(1'($urandom_range(1, 0)));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
